// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr
//  Description : N-requester round-robin bus arbiter. Latches the winner's
//                {data, address} packet at grant and serialises it LSB beat
//                first onto a BEATW-wide valid/ready bus. Grants run back to
//                back with no idle bubble. Each requester gets a completion
//                pulse when its final beat is accepted.
//  Options     : BUS_ARB_WATCHDOG_EN - adds a stall watchdog. It aborts a
//                transaction after WDT_CYCLES stalled beats and pulses err.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
  parameter int NREQ  = 4,
  parameter int ADDRW = 24,
  parameter int BEATW = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*(ADDRW+8)-1:0] data_in,
  input  logic                      bus_ready,
  output logic [BEATW-1:0]          data_out,
  output logic                      valid_out,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic                      err
);

  localparam int PKTW   = ADDRW + 8;
  localparam int NBEATS = PKTW / BEATW;
  localparam int CNTW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PTRW   = $clog2(NREQ);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBEATS - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [PTRW-1:0] PTR_INIT = PTRW'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic [NREQ-1:0]   r_grant,  w_grant_nxt;
  logic [NREQ-1:0]   r_done,   w_done_nxt;
  logic [CNTW-1:0]   r_cnt,    w_cnt_nxt;
  logic [PKTW-1:0]   r_shift,  w_shift_nxt;
  logic [PTRW-1:0]   r_last,   w_last_nxt;

  logic              w_any;
  logic [PTRW-1:0]   w_win;
  logic [PTRW-1:0]   w_scan;
  logic [NREQ-1:0]   w_win_oh;
  logic              w_accept;
  logic              w_final;
  logic              w_abort;
  logic              w_rearb;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int         WDT_CYCLES = 255;
  localparam logic [7:0] WDT_TRIP   = 8'(WDT_CYCLES - 1);

  logic [7:0] r_stall, w_stall_nxt;
  logic       r_err;

  // The stall that would bring the counter to WDT_CYCLES aborts on this edge
  assign w_abort = (r_state == ST_XFER) && !bus_ready && (r_stall == WDT_TRIP);
  assign err     = r_err;
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  assign valid_out = (r_state == ST_XFER);
  assign data_out  = r_shift[BEATW-1:0];
  assign grant     = r_grant;
  assign done      = r_done;

  // Round-robin pick: the first set req scanning upward from last+1 with wrap.
  // The scan runs from the farthest offset down so the nearest hit wins.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_scan   = '0;
    w_win_oh = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_scan = PTRW'((int'(r_last) + i) % NREQ);
      if (req[w_scan]) begin
        w_any = 1'b1;
        w_win = w_scan;
      end
    end
    w_win_oh[w_win] = 1'b1;
  end

  // Next-state logic. Arbitration re-runs in IDLE, on a final beat and on a
  // watchdog abort. r_last already holds the served index in the last two
  // cases, so the served requester ends up with the lowest priority.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_last_nxt  = r_last;
    w_done_nxt  = '0;
    w_accept    = (r_state == ST_XFER) && bus_ready;
    w_final     = w_accept && (r_cnt == CNT_LAST);
    w_rearb     = (r_state == ST_IDLE) || w_final || w_abort;

    if (w_rearb) begin
      w_cnt_nxt = '0;
      if (w_any) begin
        w_state_nxt = ST_XFER;
        w_grant_nxt = w_win_oh;
        w_shift_nxt = data_in[int'(w_win)*PKTW +: PKTW];
        w_last_nxt  = w_win;
      end else begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_shift_nxt = '0;
      end
    end else if (w_accept) begin
      w_shift_nxt = r_shift >> BEATW;
      w_cnt_nxt   = r_cnt + CNT_ONE;
    end

    if (w_final) begin
      w_done_nxt = r_grant;
    end
  end

`ifdef BUS_ARB_WATCHDOG_EN
  // Stall counter: counts stalled beats and clears on acceptance, a new grant or IDLE
  always_comb begin
    w_stall_nxt = '0;
    if ((r_state == ST_XFER) && !bus_ready && !w_abort) begin
      w_stall_nxt = r_stall + 8'd1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      r_stall <= w_stall_nxt;
      r_err   <= w_abort;
    end
  end
`endif

  // State register; reset discards any in-flight packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_last  <= PTR_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_rr
//  Description : Self-checking bench for bus_arbiter_rr. It uses a hand-written
//                vector table, directed corner sequences and randomized
//                traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

  localparam int NREQ   = 4;
  localparam int ADDRW  = 24;
  localparam int BEATW  = 8;
  localparam int PKTW   = ADDRW + 8;
  localparam int NBEATS = PKTW / BEATW;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*PKTW-1:0] data_in;
  logic                 bus_ready;
  logic [BEATW-1:0]     data_out;
  logic                 valid_out;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 err;

  int n_vec  = 0;
  int n_miss = 0;

  bus_arbiter_rr #(.NREQ(NREQ), .ADDRW(ADDRW), .BEATW(BEATW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .bus_ready (bus_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grant     (grant),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: owner + queue of pending beats ----------
  bit               m_busy;
  int               m_owner;
  int               m_last;
  int               m_stall;
  logic [BEATW-1:0] m_beats[$];
  logic [NREQ-1:0]  m_done;
  logic             m_err;

  task automatic m_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_stall = 0;
    m_beats.delete();
    m_done  = '0;
    m_err   = 1'b0;
  endtask

  task automatic m_step(input logic [NREQ-1:0] r, input logic rdy,
                        input logic [NREQ*PKTW-1:0] din);
    logic [PKTW-1:0] pkt;
    bit              found;
    int              c;
    m_done = '0;
    m_err  = 1'b0;
    if (m_busy) begin
      if (rdy) begin
        void'(m_beats.pop_front());
        m_stall = 0;
        if (m_beats.size() == 0) begin
          m_done[m_owner] = 1'b1;
          m_busy = 0;
        end
      end else begin
`ifdef BUS_ARB_WATCHDOG_EN
        m_stall++;
        if (m_stall == 255) begin
          m_err  = 1'b1;
          m_busy = 0;
          m_beats.delete();
        end
`endif
      end
    end
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (!found && r[c]) begin
          found   = 1;
          m_busy  = 1;
          m_owner = c;
          m_last  = c;
          m_stall = 0;
          pkt     = din[c*PKTW +: PKTW];
          for (int b = 0; b < NBEATS; b++) m_beats.push_back(pkt[b*BEATW +: BEATW]);
        end
      end
    end
  endtask

  // ---------------- comparison helpers ----------------
  task automatic compare(input string name, input logic [NREQ-1:0] eg, input logic ev,
                         input logic [BEATW-1:0] ed, input logic [NREQ-1:0] edn,
                         input logic ee);
    n_vec++;
    if ({grant, valid_out, data_out, done, err} !== {eg, ev, ed, edn, ee}) begin
      n_miss++;
      $display("FAIL %s @%0t: got grant=%b valid=%b data=%h done=%b err=%b, want grant=%b valid=%b data=%h done=%b err=%b",
               name, $time, grant, valid_out, data_out, done, err, eg, ev, ed, edn, ee);
    end
  endtask

  task automatic compare_model(input string name);
    logic [NREQ-1:0]  eg;
    logic [BEATW-1:0] ed;
    eg = '0;
    ed = '0;
    if (m_busy) begin
      eg[m_owner] = 1'b1;
      ed = m_beats[0];
    end
    compare(name, eg, logic'(m_busy), ed, m_done, m_err);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One clock: the model consumes the inputs present at the edge, then outputs are compared
  task automatic cycle(input string name);
    @(posedge clk);
    m_step(req, bus_ready, data_in);
    #1;
    compare_model(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    #2;
    m_reset();
    compare("reset_state", '0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NREQ-1:0]  req;
    logic             rdy;
    logic [NREQ-1:0]  grant;
    logic             valid;
    logic [BEATW-1:0] dout;
    logic [NREQ-1:0]  done;
  } vec_t;

  vec_t tbl[6];

  int               ngrant;
  logic [NREQ-1:0]  gseq[$];
  logic [NREQ-1:0]  prev_g;
  int               bubbles;
  int               done_cnt;
  int               err_cnt;
  logic [PKTW-1:0]  saved;

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    bus_ready = 1'b0;
    data_in   = {32'h0BADC0DE, 32'hCAFEF00D, 32'h44332211, 32'hDEADBEEF};
    m_reset();

    // Single transaction with bus_ready held high: beats arrive LSB first
    tbl[0] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'hEF, 4'b0000};
    tbl[1] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 8'hBE, 4'b0000};
    tbl[2] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 8'hAD, 4'b0000};
    tbl[3] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 8'hDE, 4'b0000};
    tbl[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0001};
    tbl[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      req       = tbl[i].req;
      bus_ready = tbl[i].rdy;
      @(posedge clk);
      m_step(req, bus_ready, data_in);
      #1;
      compare($sformatf("table[%0d]", i), tbl[i].grant, tbl[i].valid, tbl[i].dout,
              tbl[i].done, 1'b0);
    end

    // Saturating round robin: order 0,1,2,3,0 and no bubble between grants
    do_reset();
    req       = 4'b1111;
    bus_ready = 1'b1;
    prev_g    = '0;
    bubbles   = 0;
    for (int i = 0; i < 4*NBEATS + 2; i++) begin
      cycle("rr_saturate");
      if (grant != prev_g) gseq.push_back(grant);
      if (i > 0 && !valid_out) bubbles++;
      prev_g = grant;
    end
    check_int("rr_grant_changes", gseq.size(), 5);
    if (gseq.size() >= 5) begin
      check_int("rr_order0", int'(gseq[0]), 1);
      check_int("rr_order1", int'(gseq[1]), 2);
      check_int("rr_order2", int'(gseq[2]), 4);
      check_int("rr_order3", int'(gseq[3]), 8);
      check_int("rr_order4", int'(gseq[4]), 1);
    end
    check_int("rr_bubbles", bubbles, 0);

    // Backpressure: data_out holds while bus_ready is low
    do_reset();
    req       = 4'b0001;
    bus_ready = 1'b1;
    cycle("bp_grant");
    req      = '0;
    done_cnt = 0;
    foreach (tbl[i]) begin end
    for (int i = 0; i < 8; i++) begin
      bus_ready = (i < 7) ? logic'((7'b1011001 >> (6 - i)) & 7'd1) : 1'b0;
      cycle("bp_toggle");
      if (done[0]) done_cnt++;
    end
    check_int("bp_done_count", done_cnt, 1);

    // Packet latched at grant: later data_in changes do not reach the bus
    do_reset();
    req       = 4'b0100;
    bus_ready = 1'b1;
    saved     = data_in[2*PKTW +: PKTW];
    cycle("latch_grant");
    data_in[2*PKTW +: PKTW] = ~saved;
    req = '0;
    for (int i = 0; i < NBEATS + 1; i++) cycle("latch_hold");
    data_in[2*PKTW +: PKTW] = saved;

    // Asynchronous reset in the middle of a transfer
    do_reset();
    req       = 4'b0001;
    bus_ready = 1'b1;
    cycle("mid_rst_grant");
    req = '0;
    cycle("mid_rst_beat");
    cycle("mid_rst_beat");
    rst_n = 1'b0;
    #1;
    m_reset();
    compare("mid_rst_async", '0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0100;
    cycle("post_rst_grant");
    req = '0;
    for (int i = 0; i < NBEATS + 1; i++) cycle("post_rst_xfer");

`ifdef BUS_ARB_WATCHDOG_EN
    // Watchdog: req[1] stalls forever, aborted at 255 stalls, grant moves to 3
    do_reset();
    req       = 4'b1010;
    bus_ready = 1'b0;
    err_cnt   = 0;
    done_cnt  = 0;
    for (int i = 0; i < 300; i++) begin
      cycle("wdt_stall");
      if (err) err_cnt++;
      if (done[1]) done_cnt++;
    end
    check_int("wdt_err_pulses", err_cnt, 1);
    check_int("wdt_no_done1", done_cnt, 0);
    check_int("wdt_grant_moved", int'(grant), 8);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req       = NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) data_in = {$urandom, $urandom, $urandom, $urandom};
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
